display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
Shares the board display resource (24-bit seven-segment value, 24-bit LED word, blink request) between two requesters: requester 0 is the CPU MMIO write path and requester 1 is the status/exception reporter. It grants one requester at a time and latches that requester's payload. It holds ownership for a minimum dwell time so a message stays readable. Its outputs drive the display driver's data_display, led_display and blink_need inputs directly.

Parameters:
HOLD_CYCLES, 100_000_000, minimum ownership dwell in clk cycles after the last accepted write (1 s at 100 MHz); must be >= 2.
RESET_DATA, 24'd0, value driven on disp_data after reset.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
req  input  2  per-requester write request, level; bit i = requester i
data0  input  24  requester 0 seven-segment value
led0  input  24  requester 0 LED word
blink0  input  1  requester 0 blink request
data1  input  24  requester 1 seven-segment value
led1  input  24  requester 1 LED word
blink1  input  1  requester 1 blink request
ack  output  2  one-cycle accept pulse per requester
disp_data  output  24  to display data_display
disp_led  output  24  to display led_display
disp_blink  output  1  to display blink_need
owner  output  1  index of current/last granted requester
busy  output  1  high while in HOLD state

Behaviour:
- Reset (async, any state): state=IDLE, ack=0, disp_data=RESET_DATA, disp_led=0, disp_blink=0, owner=0, last_grant=1 (so requester 0 wins the first tie), hold counter=0. Reset mid-HOLD abandons the grant. No ack is issued for a request pending at reset.
- States: IDLE, HOLD.
- IDLE:
  - Sample req on each clk edge.
  - Exactly one bit set: grant that requester.
  - Both bits set: grant the index != last_grant (round-robin).
  - Grant edge, all registered simultaneously: disp_data/disp_led/disp_blink <= the granted requester's inputs; owner and last_grant <= index; ack[index]=1 for exactly one cycle; counter <= HOLD_CYCLES-1; state <= HOLD.
  - Latency: req high before edge N gives ack and updated outputs after edge N.
- HOLD:
  - busy=1.
  - Counter decrements by 1 each cycle.
  - req[owner] high: accepted as a rewrite. Payload re-latched, ack[owner] pulses, counter reloads to HOLD_CYCLES-1.
  - req of the non-owner: ignored (no ack, no change) while in HOLD.
  - Counter==0 with no owner rewrite on that edge: state <= IDLE.
  - Counter==0 with an owner rewrite on the same edge: the rewrite wins; reload and stay in HOLD.
  - Non-owner pending at expiry: serviced in IDLE on the next edge. It is granted because last_grant==owner. Worst-case wait is HOLD_CYCLES+1 cycles after the owner's last ack.
- Handshake rules:
  - Requester keeps req high until it sees ack, then drops req the following cycle.
  - A req still high the cycle after its ack counts as a new request. In HOLD this means a rewrite; in IDLE it means a new grant.
  - Payload inputs are sampled only on the accept edge.
  - ack is never high for both bits at once.
  - ack is never high in a cycle not preceded by the corresponding req.
- Display persistence: on HOLD->IDLE, disp_* and owner retain their last values. The display keeps showing the last message until a new grant.
- Counter width: clog2(HOLD_CYCLES). No wrap: it never decrements below 0.
- Fully synchronous to clk except rst. No combinational path from req to disp_* or ack.

Test Plan:
HOLD_CYCLES=4 throughout.
- Reset release, req=2'b00 for 10 cycles -> disp_data=0, disp_led=0, disp_blink=0, busy=0, ack=0 throughout.
- req=2'b01, data0=24'd123456, led0=24'h00FF00, blink0=1, held one cycle -> ack=2'b01 for one cycle one edge later. disp_data=123456, disp_led=00FF00, disp_blink=1, busy=1 for 4 cycles then 0. Values persist afterwards.
- req=2'b11 from IDLE after reset -> requester 0 acked first. req[1] held high is ignored during HOLD, then acked exactly 5 cycles after ack[0] with data1 shown and owner=1.
- Owner 0 re-requests with data0=7 at counter==0 -> ack[0], disp_data=7, HOLD extends 4 more cycles, no IDLE cycle occurs.
- Non-owner req[1] pulsed 2 cycles mid-HOLD, then dropped -> no ack[1], outputs unchanged.
- rst asserted asynchronously mid-HOLD (between edges) -> outputs return to reset values immediately. After release, pending req=2'b10 is granted on the first edge.

Source files
------------

// File: rtl/display_arbiter_if.sv
// Requester-side and display-side signals of the display arbiter.
// master = requesters/display driver side, slave = arbiter.
interface display_arbiter_if;
   logic [1:0]  req;
   logic [23:0] data0;
   logic [23:0] led0;
   logic        blink0;
   logic [23:0] data1;
   logic [23:0] led1;
   logic        blink1;
   logic [1:0]  ack;
   logic [23:0] disp_data;
   logic [23:0] disp_led;
   logic        disp_blink;
   logic        owner;
   logic        busy;

   modport master (
      output req, data0, led0, blink0, data1, led1, blink1,
      input  ack, disp_data, disp_led, disp_blink, owner, busy
   );

   modport slave (
      input  req, data0, led0, blink0, data1, led1, blink1,
      output ack, disp_data, disp_led, disp_blink, owner, busy
   );
endinterface

// File: rtl/display_arbiter.sv
// Two-requester display arbiter: round-robin grant, payload latch and a minimum
// ownership dwell so a shown message stays readable.
module display_arbiter #(
   parameter int unsigned HOLD_CYCLES = 100_000_000,
   parameter logic [23:0] RESET_DATA  = 24'd0
) (
   input logic             clk,
   input logic             rst,
   display_arbiter_if.slave bus
);
   localparam int unsigned   CW     = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, HOLD} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    ack_q, ack_d;
   logic [23:0]   data_q, data_d;
   logic [23:0]   led_q, led_d;
   logic          blink_q, blink_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic          grant;
   logic          gidx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 2'b00;
         data_q  <= RESET_DATA;
         led_q   <= 24'd0;
         blink_q <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;  // requester 0 wins the first tie
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         led_q   <= led_d;
         blink_q <= blink_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 2'b00;
      data_d  = data_q;
      led_d   = led_q;
      blink_d = blink_q;
      owner_d = owner_q;
      last_d  = last_q;
      grant   = 1'b0;
      gidx    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req != 2'b00) begin
               grant = 1'b1;
               gidx  = (bus.req == 2'b11) ? ~last_q : bus.req[1];
            end
         end
         HOLD: begin
            // Only the owner may rewrite; an owner rewrite beats expiry.
            if (bus.req[owner_q]) begin
               grant = 1'b1;
               gidx  = owner_q;
            end else if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant) begin
         data_d      = gidx ? bus.data1  : bus.data0;
         led_d       = gidx ? bus.led1   : bus.led0;
         blink_d     = gidx ? bus.blink1 : bus.blink0;
         owner_d     = gidx;
         last_d      = gidx;
         ack_d[gidx] = 1'b1;
         cnt_d       = RELOAD;
         state_d     = HOLD;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.disp_data  = data_q;
   assign bus.disp_led   = led_q;
   assign bus.disp_blink = blink_q;
   assign bus.owner      = owner_q;
   assign bus.busy       = (state_q == HOLD);
endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed scenarios plus random requests, all
// outputs compared every cycle against a timestamp-based ownership model.
module tb_display_arbiter;
   localparam int H = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   display_arbiter_if u_if();

   display_arbiter #(.HOLD_CYCLES(H), .RESET_DATA(24'd0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: ownership lasts while fewer than H+1 edges have passed since the
   // last accepted write; an expired owner leaves the field open to both.
   logic [1:0]  m_ack;
   logic [23:0] m_data, m_led;
   logic        m_blink, m_owner, m_last, m_busy;
   bit          m_have;
   int          ecnt, lastacc, acc;
   bit          in_hold;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ack = 0; m_data = 0; m_led = 0; m_blink = 0;
         m_owner = 0; m_last = 1; m_have = 0; m_busy = 0;
         ecnt = 0; lastacc = 0;
      end else begin
         ecnt++;
         in_hold = m_have && (ecnt - lastacc <= H);
         acc = -1;
         if (in_hold) begin
            if (u_if.req[m_owner]) acc = m_owner;
         end else if (u_if.req == 2'b11) acc = m_last ? 0 : 1;
         else if (u_if.req[0]) acc = 0;
         else if (u_if.req[1]) acc = 1;
         m_ack = 0;
         if (acc >= 0) begin
            m_data  = (acc == 1) ? u_if.data1  : u_if.data0;
            m_led   = (acc == 1) ? u_if.led1   : u_if.led0;
            m_blink = (acc == 1) ? u_if.blink1 : u_if.blink0;
            m_owner = (acc == 1);
            m_last  = (acc == 1);
            m_ack[acc] = 1'b1;
            lastacc = ecnt;
            m_have  = 1;
         end
         m_busy = m_have && (ecnt - lastacc < H);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_ack",   32'(u_if.ack),        32'(m_ack));
         chk("m_data",  32'(u_if.disp_data),  32'(m_data));
         chk("m_led",   32'(u_if.disp_led),   32'(m_led));
         chk("m_blink", 32'(u_if.disp_blink), 32'(m_blink));
         chk("m_owner", 32'(u_if.owner),      32'(m_owner));
         chk("m_busy",  32'(u_if.busy),       32'(m_busy));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b1;
      u_if.req = 0; u_if.data0 = 0; u_if.led0 = 0; u_if.blink0 = 0;
      u_if.data1 = 0; u_if.led1 = 0; u_if.blink1 = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_data", 32'(u_if.disp_data), 0);
         chk("idle_busy", 32'(u_if.busy), 0);
         chk("idle_ack",  32'(u_if.ack), 0);
      end

      // single grant, one-cycle request
      u_if.data0 = 24'd123456; u_if.led0 = 24'h00FF00; u_if.blink0 = 1; u_if.req = 2'b01;
      @(negedge clk);
      u_if.req = 2'b00;
      chk("t2_ack",   32'(u_if.ack), 32'h1);
      chk("t2_data",  32'(u_if.disp_data), 32'd123456);
      chk("t2_led",   32'(u_if.disp_led), 32'h00FF00);
      chk("t2_blink", 32'(u_if.disp_blink), 1);
      chk("t2_busy0", 32'(u_if.busy), 1);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("t2_busy", 32'(u_if.busy), (i < H) ? 1 : 0);
         chk("t2_ack0", 32'(u_if.ack), 0);
         chk("t2_keep", 32'(u_if.disp_data), 32'd123456);
      end

      // tie after reset: requester 0 first, requester 1 after the dwell
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      u_if.data0 = 24'd11; u_if.data1 = 24'd22; u_if.led1 = 24'hABCDEF; u_if.blink1 = 0;
      u_if.req = 2'b11;
      @(negedge clk);
      chk("t3_first", 32'(u_if.ack), 32'h1);
      u_if.req = 2'b10;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (u_if.ack[1]) break;
      end
      u_if.req = 2'b00;
      chk("t3_wait",  n, 5);
      chk("t3_data",  32'(u_if.disp_data), 32'd22);
      chk("t3_owner", 32'(u_if.owner), 1);

      // owner rewrite exactly at counter expiry
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!u_if.busy) break;
      end
      u_if.data0 = 24'd5; u_if.req = 2'b01;
      @(negedge clk);
      chk("t4_ack", 32'(u_if.ack), 32'h1);
      u_if.req = 2'b00;
      repeat (3) @(negedge clk);
      chk("t4_busy_last", 32'(u_if.busy), 1);
      u_if.data0 = 24'd7; u_if.req = 2'b01;
      @(negedge clk);
      u_if.req = 2'b00;
      chk("t4_rack", 32'(u_if.ack), 32'h1);
      chk("t4_data", 32'(u_if.disp_data), 32'd7);
      chk("t4_busy", 32'(u_if.busy), 1);

      // non-owner pulse in the extended hold is ignored
      @(negedge clk); u_if.data1 = 24'd99; u_if.req = 2'b10;
      @(negedge clk); chk("t5_ack_a", 32'(u_if.ack), 0);
      @(negedge clk); u_if.req = 2'b00;
      chk("t5_ack_b", 32'(u_if.ack), 0);
      chk("t5_data",  32'(u_if.disp_data), 32'd7);
      @(negedge clk);
      chk("t5_ack_c", 32'(u_if.ack), 0);
      chk("t5_busy",  32'(u_if.busy), 0);
      chk("t5_owner", 32'(u_if.owner), 0);
      chk("t5_keep",  32'(u_if.disp_data), 32'd7);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         u_if.req    = 2'($urandom_range(0, 3));
         u_if.data0  = 24'($urandom); u_if.led0 = 24'($urandom); u_if.blink0 = 1'($urandom);
         u_if.data1  = 24'($urandom); u_if.led1 = 24'($urandom); u_if.blink1 = 1'($urandom);
      end
      @(negedge clk); u_if.req = 2'b00;
      repeat (10) @(negedge clk);

      // async reset in the middle of a hold
      u_if.data1 = 24'h000123; u_if.req = 2'b10;
      @(negedge clk);
      u_if.req = 2'b00;
      chk("t6_grant", 32'(u_if.ack), 32'h2);
      @(posedge clk); #3;
      rst = 1'b1; u_if.data1 = 24'h000456; u_if.req = 2'b10;
      #1;
      chk("t6_rdata",  32'(u_if.disp_data), 0);
      chk("t6_rled",   32'(u_if.disp_led), 0);
      chk("t6_rblink", 32'(u_if.disp_blink), 0);
      chk("t6_rbusy",  32'(u_if.busy), 0);
      chk("t6_rack",   32'(u_if.ack), 0);
      chk("t6_rowner", 32'(u_if.owner), 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      u_if.req = 2'b00;
      chk("t6_ack",   32'(u_if.ack), 32'h2);
      chk("t6_data",  32'(u_if.disp_data), 32'h000456);
      chk("t6_owner", 32'(u_if.owner), 1);
      chk("t6_busy",  32'(u_if.busy), 1);
      repeat (8) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
